// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the EX stage and the muldiv unit.
//   A, B   : 32-bit operands (multiplicand/dividend, multiplier/divisor;
//            A is also the mthi/mtlo source)
//   op     : 3-bit operation code, qualified by start
//   start  : request valid
//   hi, lo : architectural HI/LO registers
//   busy   : unit is working on a mult/div, pipeline must stall
//   done   : one-cycle pulse in the cycle after a mult/div result lands
// master = requester (EX stage / testbench), slave = muldiv unit.
interface muldiv_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  op;
    logic        start;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (
        output A, B, op, start,
        input  hi, lo, busy, done
    );

    modport slave (
        input  A, B, op, start,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv.sv
// muldiv: iterative 32x32 multiply / 32/32 divide unit for MIPS
// mult, multu, div, divu, mthi and mtlo.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : muldiv_if.slave (A, B, op, start in; hi, lo, busy, done out)
// A mult/div is accepted in IDLE, runs 32 one-bit iterations in CALC on
// operand magnitudes, then FIX applies the sign correction and writes
// hi/lo. mthi/mtlo complete in the accepting cycle. Requests arriving
// while busy are dropped.
module muldiv (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state_reg, state_next;

    logic [31:0] a_reg;        // |A|; shifted left during divide
    logic [31:0] b_reg;        // |B|; shifted right during multiply
    logic [63:0] acc_reg;      // product, or {remainder, quotient}
    logic [4:0]  cnt_reg;
    logic        is_div_reg;
    logic        neg_q_reg;    // negate product / quotient
    logic        neg_r_reg;    // negate remainder (dividend was negative)
    logic        dz_reg;       // divide by zero
    logic [31:0] araw_reg;     // untouched A, returned in hi on divide by zero
    logic [31:0] hi_reg, lo_reg;
    logic        done_reg;

    logic        is_md_op;
    logic        is_signed_op;
    logic        sign_a, sign_b;
    logic        accept_md;

    assign is_md_op     = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                          (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign is_signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign sign_a       = is_signed_op & bus.A[31];
    assign sign_b       = is_signed_op & bus.B[31];
    assign accept_md    = (state_reg == IDLE) && bus.start && is_md_op;

    // Multiply step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the 65-bit result right.
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, acc_reg[63:32]} + (b_reg[0] ? {1'b0, a_reg} : 33'd0);

    // Restoring divide step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. The shifted value is
    // always below twice the divisor, so the kept remainder fits 32 bits.
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [31:0] div_rem;
    assign div_shift = {acc_reg[63:32], a_reg[31]};
    assign div_diff  = div_shift - {1'b0, b_reg};
    assign div_ge    = (div_shift >= {1'b0, b_reg});
    assign div_rem   = div_ge ? div_diff[31:0] : div_shift[31:0];

    // Sign correction applied in FIX.
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    assign prod_fix = neg_q_reg ? (64'd0 - acc_reg) : acc_reg;
    assign quo_fix  = neg_q_reg ? (32'd0 - acc_reg[31:0])  : acc_reg[31:0];
    assign rem_fix  = neg_r_reg ? (32'd0 - acc_reg[63:32]) : acc_reg[63:32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept_md) state_next = CALC;
            CALC:    if (cnt_reg == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            dz_reg     <= 1'b0;
            araw_reg   <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept_md) begin
                        a_reg      <= sign_a ? (32'd0 - bus.A) : bus.A;
                        b_reg      <= sign_b ? (32'd0 - bus.B) : bus.B;
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                        is_div_reg <= (bus.op == OP_DIV) || (bus.op == OP_DIVU);
                        neg_q_reg  <= sign_a ^ sign_b;
                        neg_r_reg  <= sign_a;
                        dz_reg     <= (bus.B == 32'd0);
                        araw_reg   <= bus.A;
                    end else if (bus.start && bus.op == OP_MTHI) begin
                        hi_reg <= bus.A;
                    end else if (bus.start && bus.op == OP_MTLO) begin
                        lo_reg <= bus.A;
                    end
                end
                CALC: begin
                    cnt_reg <= cnt_reg + 5'd1;
                    if (is_div_reg) begin
                        acc_reg <= {div_rem, acc_reg[30:0], div_ge};
                        a_reg   <= {a_reg[30:0], 1'b0};
                    end else begin
                        acc_reg <= {mul_sum, acc_reg[31:1]};
                        b_reg   <= {1'b0, b_reg[31:1]};
                    end
                end
                FIX: begin
                    done_reg <= 1'b1;
                    if (!is_div_reg) begin
                        hi_reg <= prod_fix[63:32];
                        lo_reg <= prod_fix[31:0];
                    end else if (dz_reg) begin
                        hi_reg <= araw_reg;
                        lo_reg <= 32'hFFFF_FFFF;
                    end else begin
                        hi_reg <= rem_fix;
                        lo_reg <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_reg != IDLE);
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;

endmodule

// File: doc/muldiv.md
# muldiv

Iterative multiply/divide unit for the EX stage, beside the `alu`. It takes the same `A`/`B` operand buses and handles the MIPS `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo` instructions. Results go into the architectural `hi`/`lo` registers, which feed the writeback mux next to `dout`. While an operation runs, `busy` stalls the pipeline.

## Interface
- No parameters. Width is fixed at 32 bits and the iteration count is fixed at 32.
- `clk` input, 1 bit: clock. All state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `A` input, 32 bits: operand. Multiplicand or dividend; also the `mthi`/`mtlo` source.
- `B` input, 32 bits: operand. Multiplier or divisor.
- `op` input, 3 bits:
  - 000 none
  - 001 `Mult`
  - 010 `Multu`
  - 011 `Div`
  - 100 `Divu`
  - 101 `Mthi`
  - 110 `Mtlo`
  - 111 reserved, treated as none
- `start` input, 1 bit: request valid, qualifies `op`.
- `hi` output, 32 bits: HI register. Holds the product upper word or the remainder.
- `lo` output, 32 bits: LO register. Holds the product lower word or the quotient.
- `busy` output, 1 bit: high while state is not IDLE (combinational from state).
- `done` output, 1 bit: registered single-cycle pulse, high in the cycle after `hi`/`lo` receive a mult/div result.

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE:**
  - On `start` with a mult/div op: latch |A| and |B| (unsigned ops use the raw values), latch the sign flags, clear the 64-bit accumulator, set counter to 0, go to CALC.
  - On `start` with `Mthi`/`Mtlo`: write `hi`←A or `lo`←A at that edge. State stays IDLE and `done` is not asserted.
  - With `start`=0, or op none/reserved: no change.
- **CALC:** one iteration per cycle; counter runs 0..31. After the iteration with counter 31, go to FIX.
  - Multiply: radix-2 shift-add. After 32 iterations the accumulator holds the unsigned 64-bit product of the magnitudes.
  - Divide: restoring shift-subtract. After 32 iterations it yields an unsigned quotient and remainder.
- **FIX:** apply sign correction, write `hi`/`lo`, set `done`←1 for one cycle, go to IDLE.
- **Signed multiply:** the 64-bit product is negated when sign(A) differs from sign(B).
- **Signed divide:**
  - Quotient truncates toward zero; it is negated when the signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0. No trap.
- **Divide by zero (either signedness):** `lo`=0xFFFFFFFF, `hi`=A unmodified. Latency is unchanged and there is no exception.
- **`start` while `busy`:** ignored entirely, including `Mthi`/`Mtlo`. Upstream holds the instruction until `busy` falls.
- **Operand changes during CALC/FIX:** no effect, because operands are latched at acceptance.
- **`rst` (asynchronous, any state):**
  - State→IDLE; `hi`=0, `lo`=0, `done`=0, `busy`=0, counter=0.
  - An interrupted operation never produces `done`, and `hi`/`lo` remain 0.
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `done`=0.

## Timing
- The request is accepted at edge E0 (state IDLE, `start`=1, mult/div op).
- `busy`=1 from just after E0 through the cycle ending at E33, which is 33 cycles (32 CALC + 1 FIX).
- Iterations occur at E1..E32. At E32 the state becomes FIX.
- At E33: `hi`/`lo` are updated, `done`→1, state→IDLE, and `busy` falls.
- `done` is high only between E33 and E34. The result is readable in that cycle.
- The earliest next accepted request is at E34 (back-to-back throughput is 34 cycles).
- `Mthi`/`Mtlo` take 1 cycle: new value visible immediately after the accepting edge.
- A `Mthi`/`Mtlo` request presented in the `done` cycle is accepted at E34.

## Test plan
- **Unsigned multiply:** `Multu` A=0xFFFFFFFF, B=0xFFFFFFFF. Required: `busy` high 33 cycles, then `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` a single-cycle pulse.
- **Signed multiply:** `Mult` A=0xFFFFFFFD (-3), B=7. Required: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Then `Multu` with the same operands: `hi`=0x00000006, `lo`=0xFFFFFFEB.
- **Divide signs:**
  - `Div` A=0xFFFFFFF9 (-7), B=2: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - `Divu` A=7, B=2: `lo`=3, `hi`=1.
  - `Div` A=0x80000000, B=0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- **Divide by zero:** `Divu` A=5, B=0, giving `lo`=0xFFFFFFFF, `hi`=5. `Div` A=0xFFFFFFF0, B=0, giving `lo`=0xFFFFFFFF, `hi`=0xFFFFFFF0. Both take 33 cycles.
- **Busy/start interaction:**
  - Start `Multu` 3×4.
  - Assert `Mthi` A=0x1234 and `Div` at cycle 5: both are ignored, and the result is `hi`=0, `lo`=12.
  - `Mtlo` A=0xABCD in the `done` cycle: `lo`=0xABCD after E34, with no `done` pulse.
- **Reset mid-operation:**
  - Start `Mult` 100×100, then assert `rst` asynchronously mid-cycle at cycle 10: `busy`=0, `hi`=`lo`=0 immediately, no `done` ever.
  - After release, `Multu` 2×3 gives `lo`=6 at E33.
